mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit: the sequential HI/LO companion to the combinational

---
 rtl/md_pkg.sv | 22 ++
 rtl/md_iter_datapath.sv | 54 +++++
 rtl/mult_div_unit.sv | 145 ++++++++++++++
 tb/tb_mult_div_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } md_state_e;

   localparam logic [4:0] ITER_LAST = 5'd31;

endpackage

// File: rtl/md_iter_datapath.sv
// Sign-agnostic shift-add multiplier / restoring divider, one bit per step.
// acc holds {product} for multiply and {remainder, quotient} for divide.
module md_iter_datapath #(
   parameter int WIDTH = 32
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               load_i,
   input  logic               step_mul_i,
   input  logic               step_div_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] acc_o
);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     rem_diff;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
   // partial remainder never exceeds WIDTH bits, so bit WIDTH of the diff is the borrow
   assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign rem_diff = rem_sh - {1'b0, opnd_q};

   always_comb begin
      acc_d  = acc_q;
      opnd_d = opnd_q;
      if (load_i) begin
         acc_d  = {{WIDTH{1'b0}}, a_i};
         opnd_d = b_i;
      end else if (step_mul_i) begin
         if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
         else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
      end else if (step_div_i) begin
         if (rem_diff[WIDTH]) acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         else                 acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc_q  <= '0;
         opnd_q <= '0;
      end else begin
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: 33-cycle MULT/MULTU/DIV/DIVU under start/busy,
// single-cycle MTHI/MTLO. Magnitudes iterate in the datapath; signs are fixed in FIX.
//
// state | meaning
// IDLE  | accepts start; MTHI/MTLO write here
// MUL   | 32 shift-add steps
// DIV   | 32 restoring-divide steps
// FIX   | sign correction, hi/lo written
module mult_div_unit
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             start,
   input  logic [2:0]       mdOp,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_e          state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;
   logic               res_neg_q, res_neg_d;
   logic               rem_neg_q, rem_neg_d;
   logic               is_div_q, is_div_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               load, step_mul, step_div;
   logic               signed_op, a_neg, b_neg, b_zero;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   quo, rem;

   assign signed_op = (mdOp == MD_MULT) || (mdOp == MD_DIV);
   assign a_neg     = signed_op & srcA[WIDTH-1];
   assign b_neg     = signed_op & srcB[WIDTH-1];
   assign b_zero    = (srcB == '0);
   assign a_mag     = a_neg ? -srcA : srcA;
   assign b_mag     = b_neg ? -srcB : srcB;
   assign quo       = acc[WIDTH-1:0];
   assign rem       = acc[2*WIDTH-1:WIDTH];

   md_iter_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk_i      (clk),
      .rst_n_i    (resetN),
      .load_i     (load),
      .step_mul_i (step_mul),
      .step_div_i (step_div),
      .a_i        (a_mag),
      .b_i        (b_mag),
      .acc_o      (acc)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      res_neg_d = res_neg_q;
      rem_neg_d = rem_neg_q;
      is_div_d  = is_div_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      load      = 1'b0;
      step_mul  = 1'b0;
      step_div  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               unique case (mdOp)
                  MD_MULT, MD_MULTU: begin
                     load      = 1'b1;
                     cnt_d     = '0;
                     res_neg_d = a_neg ^ b_neg;
                     rem_neg_d = 1'b0;
                     is_div_d  = 1'b0;
                     state_d   = MUL;
                  end
                  MD_DIV, MD_DIVU: begin
                     load      = 1'b1;
                     cnt_d     = '0;
                     // divide by zero keeps the all-ones quotient unnegated; remainder
                     // then restores to the raw dividend via the dividend sign
                     res_neg_d = (a_neg ^ b_neg) & ~b_zero;
                     rem_neg_d = a_neg;
                     is_div_d  = 1'b1;
                     state_d   = DIV;
                  end
                  MD_MTHI: hi_d = srcA;
                  MD_MTLO: lo_d = srcA;
                  default: ;
               endcase
            end
         end
         MUL: begin
            step_mul = 1'b1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == ITER_LAST) state_d = FIX;
         end
         DIV: begin
            step_div = 1'b1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == ITER_LAST) state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
            if (is_div_q) begin
               lo_d = res_neg_q ? -quo : quo;
               hi_d = rem_neg_q ? -rem : rem;
            end else begin
               {hi_d, lo_d} = res_neg_q ? -acc : acc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         res_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         is_div_q  <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         res_neg_q <= res_neg_d;
         rem_neg_q <= rem_neg_d;
         is_div_q  <= is_div_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed hi/lo.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  mdOp = 3'd0;
   logic [31:0] srcA = '0;
   logic [31:0] srcB = '0;
   logic        busy;
   logic [31:0] hi, lo;

   int n_tests = 0;
   int n_fail  = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .resetN (resetN),
      .start  (start),
      .mdOp   (mdOp),
      .srcA   (srcA),
      .srcB   (srcB),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   // {hi, lo} the operation must produce, from plain integer arithmetic
   function automatic logic [63:0] md_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      longint      sa64, sb64, p;
      int          sa, sb, q, r;
      logic [31:0] qv, rv;
      logic [63:0] ua, ub;
      sa64 = $signed(a);
      sb64 = $signed(b);
      sa   = $signed(a);
      sb   = $signed(b);
      ua   = {32'd0, a};
      ub   = {32'd0, b};
      case (op)
         3'd0: begin p = sa64 * sb64; return p; end
         3'd1: return ua * ub;
         3'd2: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            qv = q;
            rv = r;
            return {rv, qv};
         end
         3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'd0;
      endcase
   endfunction

   // behavioural model: result appears 33 edges after acceptance
   logic [31:0] exp_hi = '0, exp_lo = '0;
   logic [63:0] pending = '0;
   int          remaining = 0;

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         exp_hi    = '0;
         exp_lo    = '0;
         remaining = 0;
      end else if (remaining > 0) begin
         remaining = remaining - 1;
         if (remaining == 0) {exp_hi, exp_lo} = pending;
      end else if (start) begin
         case (mdOp)
            3'd0, 3'd1, 3'd2, 3'd3: begin
               pending   = md_model(mdOp, srcA, srcB);
               remaining = 33;
            end
            3'd4: exp_hi = srcA;
            3'd5: exp_lo = srcA;
            default: ;
         endcase
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("cyc_busy", {31'd0, busy}, (remaining > 0) ? 32'd1 : 32'd0);
      check("cyc_hi", hi, exp_hi);
      check("cyc_lo", lo, exp_lo);
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      mdOp  = op;
      srcA  = a;
      srcB  = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name, output int n);
      n = 0;
      while (busy === 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: busy still high after %0d cycles, required low", name, n);
      end
   endtask

   task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] prev_hi,
                      input logic [31:0] prev_lo, input logic [31:0] e_hi,
                      input logic [31:0] e_lo);
      int n;
      issue(op, a, b);
      n = 0;
      while (busy === 1'b1 && n < 50) begin
         if (n == 20) begin
            check({name, "_mid_hi"}, hi, prev_hi);
            check({name, "_mid_lo"}, lo, prev_lo);
         end
         @(negedge clk);
         n++;
      end
      check({name, "_latency"}, n, 32'd33);
      check({name, "_hi"}, hi, e_hi);
      check({name, "_lo"}, lo, e_lo);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int          n;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      logic [63:0] rexp;

      repeat (2) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      resetN = 1'b1;

      run("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
          32'hFFFF_FFFE, 32'h0000_0001);
      run("mult_m3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001,
          32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
          32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run("divu_7_2", 3'd3, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd3);
      run("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'd3, 32'd1, 32'hFFFF_FFFD);
      run("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFD,
          32'd0, 32'h8000_0000);
      run("divu_5_0", 3'd3, 32'd5, 32'd0, 32'd0, 32'h8000_0000, 32'd5, 32'hFFFF_FFFF);
      run("div_m7_0", 3'd2, 32'hFFFF_FFF9, 32'd0, 32'd5, 32'hFFFF_FFFF,
          32'hFFFF_FFF9, 32'hFFFF_FFFF);
      run("mult_min_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9,
          32'hFFFF_FFFF, 32'h4000_0000, 32'd0);

      issue(3'd5, 32'd1234, 32'd0);
      check("mtlo_busy", {31'd0, busy}, 32'd0);
      check("mtlo_lo", lo, 32'd1234);
      check("mtlo_hi", hi, 32'h4000_0000);

      issue(3'd4, 32'h0000_CAFE, 32'd0);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      check("mthi_hi", hi, 32'h0000_CAFE);

      issue(3'd6, 32'h0000_DEAD, 32'd3);
      @(negedge clk);
      check("rsvd_busy", {31'd0, busy}, 32'd0);
      check("rsvd_hi", hi, 32'h0000_CAFE);
      check("rsvd_lo", lo, 32'd1234);

      // MTHI request at cycle 10 of a DIVU must be dropped
      issue(3'd3, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      start = 1'b1;
      mdOp  = 3'd4;
      srcA  = 32'h0000_AAAA;
      @(negedge clk);
      start = 1'b0;
      wait_idle("div_ignore", n);
      check("div_ignore_hi", hi, 32'd2);
      check("div_ignore_lo", lo, 32'd14);

      // asynchronous abort at cycle 15 of a MULT
      issue(3'd0, 32'd5, 32'd6);
      repeat (14) @(negedge clk);
      #2 resetN = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      @(negedge clk);
      resetN = 1'b1;

      run("multu_2x3", 3'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd6);

      for (int i = 0; i < 6; i++) begin
         rop = 3'($urandom_range(3));
         ra  = $urandom;
         rb  = (i == 5) ? 32'd0 : $urandom;
         if (i == 2) rb = rb >> 20;
         rexp = md_model(rop, ra, rb);
         issue(rop, ra, rb);
         wait_idle("rand", n);
         check("rand_latency", n, 32'd33);
         check("rand_hi", hi, rexp[63:32]);
         check("rand_lo", lo, rexp[31:0]);
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
